// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed scan driver for an 8-digit common-anode seven-segment
//   display. A 32-bit word is shown as 8 hex digits (digit 0 = rightmost).
//   The displayed value comes from a shadow latch that is reloaded only at
//   frame wrap, so a frame never mixes two values. The first BLANK_CYCLES
//   cycles of each digit slot keep all anodes off to suppress ghosting.
//
// Parameters
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (< REFRESH_DIV)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_in     value to display; nibble k drives digit k
//   dp_mask     per-digit decimal point request, active-high
//   lz_blank    blank leading zero digits when high
//   freeze      hold the shadow latch at frame wrap when high
//   anode       digit enables, active-low (one-hot-low or all ones)
//   cathode     segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point segment, active-low
//   frame_tick  one-cycle pulse following a shadow reload
// -----------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_mask,
  input  logic        lz_blank,
  input  logic        freeze,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame_tick
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  // Scan position and frame-aligned copy of the inputs.
  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;

  logic          slot_end;
  logic          frame_wrap;

  // Combinational view of what the output registers load next.
  logic [3:0]    nib;
  logic          digit_blank;
  logic [7:0]    anode_next;
  logic [6:0]    cathode_next;
  logic          dp_next;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (dig == 3'd7);

  // ---------------------------------------------------------------------------
  // Slot / digit counters
  // ---------------------------------------------------------------------------
  // NOTE: clocked state always uses non-blocking (<=) so every register in the
  // design samples the same pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dig <= 3'd0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= dig + 3'd1;  // 3-bit counter wraps 7 -> 0 on its own
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow latch: reloaded only at frame wrap so a frame is never torn.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else if (frame_wrap && !freeze) begin
      shadow_data <= data_in;
      shadow_dp   <= dp_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves a
  // signal unassigned would infer a latch.
  always_comb begin
    nib          = 4'h0;
    digit_blank  = 1'b0;
    anode_next   = 8'hFF;
    cathode_next = 7'h7F;
    dp_next      = 1'b1;

    nib = shadow_data[{dig, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero,
    // i.e. the shadow shifted down to this digit is zero. Digit 0 always shows.
    digit_blank = lz_blank && (dig != 3'd0)
                  && ((shadow_data >> {dig, 2'b00}) == 32'h0);

    if (cnt >= BLANK_END) begin
      anode_next = ~(8'h01 << dig);
    end

    if (!digit_blank) begin
      cathode_next = seg_encode(nib);
      dp_next      = ~shadow_dp[dig];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: glitch-free pins, one cycle behind the scan state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= 8'hFF;
      cathode    <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      anode      <= anode_next;
      cathode    <= cathode_next;
      dp         <= dp_next;
      frame_tick <= frame_wrap && !freeze;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//   Self-checking bench for seven_seg_scan with REFRESH_DIV=4, BLANK_CYCLES=1.
//   A behavioural model derives the expected pins from the number of edges
//   since reset (slot = k / R, phase = k % R, wrap when k % 8R == 8R-1) and a
//   model shadow word; scenario tasks compare the pins against the model and
//   against hand-written constants for the documented cases.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = 8 * R;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic [7:0]  dp_mask;
  logic        lz_blank;
  logic        freeze;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seven_seg_scan #(
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .dp_mask   (dp_mask),
    .lz_blank  (lz_blank),
    .freeze    (freeze),
    .anode     (anode),
    .cathode   (cathode),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned m_k;
  int          m_phase;
  int          m_d;
  logic        m_blank;
  logic [31:0] m_sh;
  logic [7:0]  m_dp;
  logic [7:0]  e_an;
  logic [6:0]  e_cat;
  logic        e_dp;
  logic        e_ft;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   = 0;
      m_sh  = 32'h0;
      m_dp  = 8'h0;
      e_an  = 8'hFF;
      e_cat = 7'h7F;
      e_dp  = 1'b1;
      e_ft  = 1'b0;
    end else begin
      m_phase = int'(m_k % R);
      m_d     = int'((m_k / R) % 8);
      m_blank = lz_blank && (m_d != 0) && ((m_sh >> (4 * m_d)) == 32'h0);
      e_an    = (m_phase < B) ? 8'hFF : ~(8'h01 << m_d);
      e_cat   = m_blank ? 7'h7F : seg_tab[4'(m_sh >> (4 * m_d))];
      e_dp    = m_blank ? 1'b1 : ~m_dp[m_d];
      e_ft    = ((m_k % FRAME) == FRAME - 1) && !freeze;
      if (e_ft) begin
        m_sh = data_in;
        m_dp = dp_mask;
      end
      m_k++;
    end
  end

  // Bounded wait for a frame_tick seen at a falling edge.
  task automatic wait_frame_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] exp_an;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, cathode, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got an=%h cat=%h dp=%b ft=%b, want an=ff cat=7f dp=1 ft=0",
                 i, anode, cathode, dp, frame_tick);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp_an = ((i % R) == 0) ? 8'hFF : ~(8'h01 << (i / R));
      checks++;
      if ({anode, cathode, dp, frame_tick} !== {exp_an, 7'h40, 1'b1, (i == FRAME - 1)}) begin
        errors++;
        $display("FAIL reset_scan cyc %0d: got an=%h cat=%h dp=%b ft=%b, want an=%h cat=40 dp=1 ft=%b",
                 i, anode, cathode, dp, frame_tick, exp_an, (i == FRAME - 1));
      end
      checks++;
      if ({anode, cathode, dp, frame_tick} !== {e_an, e_cat, e_dp, e_ft}) begin
        errors++;
        $display("FAIL reset_model cyc %0d: got %h/%h/%b/%b want %h/%h/%b/%b",
                 i, anode, cathode, dp, frame_tick, e_an, e_cat, e_dp, e_ft);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] hex_exp [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    bit ok;
    data_in  = 32'h89AB_CDEF;
    lz_blank = 1'b0;
    wait_frame_tick(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hex_tick: got no frame_tick, want one within %0d cycles", FRAME + 8);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (cathode !== hex_exp[i / R]) begin
        errors++;
        $display("FAIL hex_digit %0d: got cat=%h want %h", i / R, cathode, hex_exp[i / R]);
      end
      checks++;
      if ({anode, cathode, dp, frame_tick} !== {e_an, e_cat, e_dp, e_ft}) begin
        errors++;
        $display("FAIL hex_model cyc %0d: got %h/%h/%b/%b want %h/%h/%b/%b",
                 i, anode, cathode, dp, frame_tick, e_an, e_cat, e_dp, e_ft);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp_cat;
    logic [7:0] exp_an;
    bit ok;
    data_in  = 32'h0000_00A5;
    lz_blank = 1'b1;
    wait_frame_tick(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lz_tick: got no frame_tick, want one within %0d cycles", FRAME + 8);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        exp_cat = (i / R == 0) ? 7'h12 : (i / R == 1) ? 7'h08 : (pass == 0) ? 7'h7F : 7'h40;
        exp_an  = ((i % R) == 0) ? 8'hFF : ~(8'h01 << (i / R));
        checks++;
        if ({anode, cathode, dp} !== {exp_an, exp_cat, 1'b1}) begin
          errors++;
          $display("FAIL lz_digit lz=%0d d=%0d: got an=%h cat=%h dp=%b want an=%h cat=%h dp=1",
                   1 - pass, i / R, anode, cathode, dp, exp_an, exp_cat);
        end
        checks++;
        if ({anode, cathode, dp, frame_tick} !== {e_an, e_cat, e_dp, e_ft}) begin
          errors++;
          $display("FAIL lz_model cyc %0d: got %h/%h/%b/%b want %h/%h/%b/%b",
                   i, anode, cathode, dp, frame_tick, e_an, e_cat, e_dp, e_ft);
        end
      end
      lz_blank = 1'b0;  // takes effect on the very next edge
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    data_in = 32'h1111_1111;
    wait_frame_tick(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tear_tick: got no frame_tick, want one within %0d cycles", FRAME + 8);
    end
    // Old frame: change the input while digit 3 is scanning.
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i / R >= 3) begin
        checks++;
        if (cathode !== 7'h79) begin
          errors++;
          $display("FAIL tear_old d=%0d: got cat=%h want 79", i / R, cathode);
        end
      end
      if (i == FRAME - 1) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++;
          $display("FAIL tear_wrap_tick: got ft=%b want 1", frame_tick);
        end
      end
      if (i == 3 * R) data_in = 32'h2222_2222;
    end
    // New frame shows the new value everywhere.
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({cathode, anode, dp, frame_tick} !== {7'h24, e_an, e_dp, e_ft}) begin
        errors++;
        $display("FAIL tear_new cyc %0d: got cat=%h an=%h dp=%b ft=%b want cat=24 an=%h dp=%b ft=%b",
                 i, cathode, anode, dp, frame_tick, e_an, e_dp, e_ft);
      end
    end
  endtask

  task automatic test_freeze_dp();
    bit ok;
    freeze  = 1'b1;
    data_in = 32'h3333_3333;
    dp_mask = 8'hFF;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, cathode, dp} !== {1'b0, 7'h24, 1'b1}) begin
        errors++;
        $display("FAIL freeze_hold cyc %0d: got ft=%b cat=%h dp=%b want ft=0 cat=24 dp=1",
                 i, frame_tick, cathode, dp);
      end
      if (i == FRAME) data_in = 32'h4444_4444;
    end
    freeze  = 1'b0;
    data_in = 32'h1234_5678;
    dp_mask = 8'h04;
    wait_frame_tick(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL unfreeze_tick: got no frame_tick, want one within %0d cycles", FRAME + 8);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (dp !== ((i / R) != 2)) begin
        errors++;
        $display("FAIL dp_digit d=%0d: got dp=%b want %b", i / R, dp, ((i / R) != 2));
      end
      checks++;
      if ({anode, cathode, dp, frame_tick} !== {e_an, e_cat, e_dp, e_ft}) begin
        errors++;
        $display("FAIL dp_model cyc %0d: got %h/%h/%b/%b want %h/%h/%b/%b",
                 i, anode, cathode, dp, frame_tick, e_an, e_cat, e_dp, e_ft);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp_an;
    bit ok;
    dp_mask = 8'h00;
    wait_frame_tick(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_tick: got no frame_tick, want one within %0d cycles", FRAME + 8);
    end
    for (int i = 0; i <= 5 * R; i++) @(negedge clk);  // now scanning digit 5
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({anode, cathode, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async: got an=%h cat=%h dp=%b ft=%b want ff/7f/1/0",
               anode, cathode, dp, frame_tick);
    end
    @(negedge clk);
    checks++;
    if ({anode, cathode, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_hold: got an=%h cat=%h dp=%b ft=%b want ff/7f/1/0",
               anode, cathode, dp, frame_tick);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * R; i++) begin
      @(negedge clk);
      exp_an = ((i % R) == 0) ? 8'hFF : ~(8'h01 << (i / R));
      checks++;
      if ({anode, cathode, dp} !== {exp_an, 7'h40, 1'b1}) begin
        errors++;
        $display("FAIL midrst_resume cyc %0d: got an=%h cat=%h dp=%b want an=%h cat=40 dp=1",
                 i, anode, cathode, dp, exp_an);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ((i % 8) == 0) begin
        data_in  = $urandom >> (4 * $urandom_range(0, 8));
        dp_mask  = 8'($urandom);
        lz_blank = 1'($urandom_range(0, 1));
        freeze   = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      checks++;
      if ({anode, cathode, dp, frame_tick} !== {e_an, e_cat, e_dp, e_ft}) begin
        errors++;
        $display("FAIL random_model cyc %0d: got %h/%h/%b/%b want %h/%h/%b/%b",
                 i, anode, cathode, dp, frame_tick, e_an, e_cat, e_dp, e_ft);
      end
    end
    freeze = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    data_in  = 32'h0;
    dp_mask  = 8'h0;
    lz_blank = 1'b0;
    freeze   = 1'b0;
    test_reset();
    test_hex();
    test_leading_zero();
    test_tear_free();
    test_freeze_dp();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scan driver for the board's 8-digit common-anode seven-segment display. It consumes the 32-bit debug word the core's register file exports (x28, `data_to_seven_led`) and shows it as 8 hexadecimal digits. A frame-aligned shadow latch prevents tearing, and a blanking interval at the start of each digit slot suppresses ghosting. It sits in the FPGA top level between the RISC-V core and the display pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV` (0 is legal).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  32  value to display; nibble k drives digit k (digit 0 = rightmost).
- `dp_mask`  in  8  per-digit decimal point request, active-high.
- `lz_blank`  in  1  when high, leading zero digits are blanked.
- `freeze`  in  1  when high, the shadow latch is not reloaded at frame wrap.
- `anode`  out  8  digit enables, active-low, one-hot-low or all-ones.
- `cathode`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point segment, active-low.
- `frame_tick`  out  1  one-cycle pulse marking a shadow reload.

## Operation
- State registers:
  - `cnt`: 0..`REFRESH_DIV`-1.
  - `dig`: 0..7.
  - `shadow_data` (32 bits) and `shadow_dp` (8 bits).
- Slot advance: `cnt` increments every cycle. At `cnt`==`REFRESH_DIV`-1, `cnt` returns to 0 and `dig` increments. `dig` wraps 7→0.
- Frame wrap occurs when `cnt`==`REFRESH_DIV`-1 and `dig`==7. On that edge:
  - if `freeze`==0: `shadow_data`<=`data_in` and `shadow_dp`<=`dp_mask`; `frame_tick` is 1 in the following cycle.
  - if `freeze`==1: shadow registers hold and `frame_tick` stays 0.
- Nibble select: `nib` = `shadow_data[4*dig+3 : 4*dig]`.
- Leading-zero rule: digit d is blank when `lz_blank`=1, d≠0, and nibbles d..7 of `shadow_data` are all zero. Digit 0 is never blank.
- Hex encode, active-low cathode {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Output registers, updated each edge from the pre-edge state:
  - `anode` <= 8'hFF if `cnt` < `BLANK_CYCLES`, otherwise 8'hFF with bit `dig` cleared.
  - `cathode` <= 7'h7F if the digit is blank, otherwise the encoded `nib`.
  - `dp` <= ~`shadow_dp[dig]`, forced to 1 when the digit is blank.
- `data_in`, `dp_mask`, `lz_blank` and `freeze` are synchronous to `clk`; no internal synchronizers.

## Timing
- Reset (`rst_n`=0) asserts asynchronously and holds while low:
  - `cnt`=0, `dig`=0, shadows=0.
  - `anode`=8'hFF, `cathode`=7'h7F, `dp`=1, `frame_tick`=0.
- After reset release, the display shows value 0 (digit 0 "0"; digits 1..7 "0", or blank if `lz_blank`) until the first frame wrap, 8×`REFRESH_DIV` cycles later.
- Outputs lag internal state by one cycle.
- Slot timing, with slot edge defined as the cycle after `cnt` wraps:
  - The first `BLANK_CYCLES` output cycles of a slot have `anode`=FF.
  - The remaining `REFRESH_DIV`-`BLANK_CYCLES` cycles drive the digit.
- Frame period is exactly 8×`REFRESH_DIV` cycles, and `frame_tick` is high once per frame.
- Shadow reload and the first output of digit 0 in the new frame appear in consecutive cycles: shadow updates on the edge where `frame_tick` rises, and the output register reflects the new data one edge later.
- Changes to `data_in` mid-frame never affect the current frame.
- `lz_blank` and `freeze` act immediately: evaluated on every edge from current shadow contents.
- Reset asserted mid-slot or mid-frame: all state returns to reset values at once, and scanning restarts at digit 0 with `cnt`=0.

## Test plan
- Reset, with `REFRESH_DIV`=4, `BLANK_CYCLES`=1, `rst_n` low for 3 cycles:
  - `anode`=FF, `cathode`=7F, `dp`=1 throughout.
  - After release, the `anode` sequence per slot is FF,FE,FE,FE, then FF,FD,FD,FD, and so on.
- Hex mapping, with `data_in`=32'h89AB_CDEF and `lz_blank`=0, after the first `frame_tick`: `cathode` over digits 0..7 = 0E,06,21,46,03,08,10,00.
- Leading zeros, with `data_in`=32'h0000_00A5 and `lz_blank`=1:
  - digit 0 → 12, digit 1 → 08.
  - digits 2..7 → `cathode`=7F, `dp`=1, anode still strobed.
  - With `lz_blank`=0, digits 2..7 → 40.
- Tear-free update:
  - Change `data_in` from 32'h1111_1111 to 32'h2222_2222 while `dig`=3. Digits 3..7 of that frame still show 79.
  - The new value (24) appears only after `frame_tick`.
- Freeze and dp:
  - With `freeze`=1 across two frames, `data_in` changes are ignored and `frame_tick` stays 0.
  - With `dp_mask`=8'h04 after reload, `dp`=0 only during digit 2's active cycles.
- Mid-frame reset: pulse `rst_n` low for 1 cycle while `dig`=5. Outputs go to reset values asynchronously, and the scan resumes at digit 0 showing 0.
